stream_check_ctrl: RTL and testbench
====================================

Name: stream_check_ctrl

Overview:
- Synthesizable check controller for the single-clock queue test harness.
- Pairs a reference message stream with a DUT output stream, compares each pair, and counts passes and fails.
- Enforces a no-progress timeout and reports done/pass as the run verdict.
- Sits between a reference source (golden queue model or ROM) and the DUT dequeue port.

Parameters:
- p_chk_nbits, 8, message width compared per check
- p_cnt_nbits, 16, width of check index and pass/fail counters
- p_timeout_period, 10000, consecutive no-fire RUN cycles before timeout; must be >= 1

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  begin a run; sampled in IDLE, DONE and TIMEOUT only
- num_checks  input  p_cnt_nbits  number of pairs to check; latched on accepted start
- ref_val  input  1  reference message valid
- ref_rdy  output  1  reference message consumed
- ref_msg  input  p_chk_nbits  expected value
- dut_val  input  1  DUT message valid
- dut_rdy  output  1  DUT message consumed
- dut_msg  input  p_chk_nbits  actual value
- done  output  1  run finished (completed or timed out)
- pass  output  1  run completed with zero fails
- timeout  output  1  run aborted by timeout
- num_passed  output  p_cnt_nbits  matching pairs this run
- num_failed  output  p_cnt_nbits  mismatching pairs this run
- fail_idx  output  p_cnt_nbits  index of first mismatch
- fail_ref  output  p_chk_nbits  expected value at first mismatch
- fail_dut  output  p_chk_nbits  actual value at first mismatch

Behaviour:
- Reset:
  - Asynchronous; state goes to IDLE.
  - All outputs and counters are 0; latched num_checks is 0.
  - Reset mid-run abandons the run with no verdict.
- States: IDLE, RUN, DONE, TIMEOUT.
- Accepted start (start=1 in IDLE, DONE or TIMEOUT):
  - Latches num_checks.
  - Clears idx, num_passed, num_failed, fail_*, the timeout counter, done, pass and timeout.
  - Next state is RUN, or DONE if num_checks==0. In that case pass=1 one cycle after start.
- start in RUN is ignored.
- Handshake in RUN:
  - ref_rdy = dut_val; dut_rdy = ref_val. Both are 0 outside RUN.
  - fire = ref_val & dut_val & RUN. Both streams are consumed in the same cycle.
  - No rdy depends combinationally on its own val.
- Compare on fire:
  - Match iff dut_msg === ref_msg (case equality). X/Z on dut_msg counts as a mismatch.
  - Match increments num_passed. Mismatch increments num_failed.
  - On the first mismatch only, capture fail_idx=idx, fail_ref and fail_dut.
  - idx increments on every fire.
- Completion:
  - When a fire brings idx to the latched num_checks, go to DONE on the next edge.
  - In DONE: done=1, pass=(num_failed==0).
- Timeout:
  - Counter clears on fire or accepted start.
  - Increments each RUN cycle without a fire.
  - When it reaches p_timeout_period, go to TIMEOUT: done=1, timeout=1, pass=0.
  - A fire in the same cycle the count would reach the limit takes priority; that cycle is not a timeout.
- Counters do not wrap. num_checks caps idx; the timeout counter saturates at p_timeout_period.
- Outputs are registered: done, pass, timeout and the counters update on the edge after the causing event.
- DONE and TIMEOUT hold until reset or the next accepted start.

Decomposition:
- Package stream_check_pkg holds:
  - typedef enum state_t {IDLE, RUN, DONE, TIMEOUT}
  - localparam of state width
- One sub-module: check_timeout_counter.
  - Parameters: period and width. Inputs: clear and inc. Output: expired.
  - Saturating; asynchronous active-high reset.

Test Plan:
- Reset then start with num_checks=4; stream ref/dut pairs 0x11,0x22,0x33,0x44 identical -> done=1, pass=1, num_passed=4, num_failed=0 one cycle after the 4th fire.
- num_checks=3; dut sends 0x01,0xFF,0x03 vs ref 0x01,0x02,0x03 -> done=1, pass=0, num_failed=1, fail_idx=1, fail_ref=0x02, fail_dut=0xFF.
- p_timeout_period=8, num_checks=2; one pair fires, then dut_val held 0 -> timeout=1, done=1, pass=0 after 8 idle RUN cycles; num_passed=1.
- ref_val=1 with dut_val=0 for 5 cycles, then dut_val=1 -> ref_rdy=0 and dut_rdy=1 during the wait; exactly one fire on cycle 6; idx=1.
- start with num_checks=0 -> DONE with pass=1 one cycle later, ref_rdy/dut_rdy never asserted.
- Assert reset mid-run after 2 of 4 checks, then start with num_checks=1 and one matching pair -> counters read 0 after reset, final num_passed=1, pass=1.

Source files
------------

// File: rtl/stream_check_pkg.sv
// Shared types for the stream check controller.
package stream_check_pkg;

  localparam int unsigned state_nbits = 2;

  typedef enum logic [state_nbits-1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

endpackage

// File: rtl/check_timeout_counter.sv
// Saturating no-progress counter; expired flags the cycle that reaches the limit.
module check_timeout_counter #(
  parameter int unsigned p_period = 10000,
  parameter int unsigned p_width  = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [p_width-1:0] count;

  // Look-ahead so the controller can leave RUN on the very edge the limit is hit.
  always_comb begin
    expired = (count == p_width'(p_period)) ||
              (inc && (count == p_width'(p_period - 1)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count < p_width'(p_period))) begin
      count <= count + p_width'(1);
    end
  end

endmodule

// File: rtl/stream_check_ctrl.sv
// Pairs reference and DUT streams, compares each pair, reports pass/fail/timeout verdict.
module stream_check_ctrl
  import stream_check_pkg::*;
#(
  parameter int unsigned p_chk_nbits      = 8,
  parameter int unsigned p_cnt_nbits      = 16,
  parameter int unsigned p_timeout_period = 10000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [p_cnt_nbits-1:0] num_checks,
  input  logic                   ref_val,
  output logic                   ref_rdy,
  input  logic [p_chk_nbits-1:0] ref_msg,
  input  logic                   dut_val,
  output logic                   dut_rdy,
  input  logic [p_chk_nbits-1:0] dut_msg,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [p_cnt_nbits-1:0] num_passed,
  output logic [p_cnt_nbits-1:0] num_failed,
  output logic [p_cnt_nbits-1:0] fail_idx,
  output logic [p_chk_nbits-1:0] fail_ref,
  output logic [p_chk_nbits-1:0] fail_dut
);

  localparam int unsigned tmo_nbits = $clog2(p_timeout_period + 1);

  state_t                 state, state_nxt;
  logic [p_cnt_nbits-1:0] n_checks, n_checks_nxt;
  logic [p_cnt_nbits-1:0] idx, idx_nxt;
  logic [p_cnt_nbits-1:0] passed_nxt, failed_nxt, fail_idx_nxt;
  logic [p_chk_nbits-1:0] fail_ref_nxt, fail_dut_nxt;
  logic                   done_nxt, pass_nxt, timeout_nxt;
  logic                   in_run, fire, start_ok, match, expired;

  // Each side's ready follows the other side's valid so both streams move together.
  always_comb begin
    in_run   = (state == RUN);
    ref_rdy  = in_run & dut_val;
    dut_rdy  = in_run & ref_val;
    fire     = in_run & ref_val & dut_val;
    start_ok = start & ~in_run;
    match    = (dut_msg === ref_msg);
  end

  check_timeout_counter #(
    .p_period (p_timeout_period),
    .p_width  (tmo_nbits)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (fire | start_ok),
    .inc     (in_run & ~fire),
    .expired (expired)
  );

  always_comb begin
    state_nxt    = state;
    n_checks_nxt = n_checks;
    idx_nxt      = idx;
    passed_nxt   = num_passed;
    failed_nxt   = num_failed;
    fail_idx_nxt = fail_idx;
    fail_ref_nxt = fail_ref;
    fail_dut_nxt = fail_dut;
    done_nxt     = done;
    pass_nxt     = pass;
    timeout_nxt  = timeout;

    unique case (state)
      IDLE, DONE, TIMEOUT: begin
        if (start) begin
          n_checks_nxt = num_checks;
          idx_nxt      = '0;
          passed_nxt   = '0;
          failed_nxt   = '0;
          fail_idx_nxt = '0;
          fail_ref_nxt = '0;
          fail_dut_nxt = '0;
          done_nxt     = 1'b0;
          pass_nxt     = 1'b0;
          timeout_nxt  = 1'b0;
          if (num_checks == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            pass_nxt  = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (fire) begin
          idx_nxt = idx + p_cnt_nbits'(1);
          if (match) begin
            passed_nxt = num_passed + p_cnt_nbits'(1);
          end else begin
            failed_nxt = num_failed + p_cnt_nbits'(1);
            if (num_failed == '0) begin
              fail_idx_nxt = idx;
              fail_ref_nxt = ref_msg;
              fail_dut_nxt = dut_msg;
            end
          end
          if (idx_nxt == n_checks) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            pass_nxt  = (failed_nxt == '0);
          end
        end else if (expired) begin
          state_nxt   = TIMEOUT;
          done_nxt    = 1'b1;
          timeout_nxt = 1'b1;
          pass_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      n_checks   <= '0;
      idx        <= '0;
      num_passed <= '0;
      num_failed <= '0;
      fail_idx   <= '0;
      fail_ref   <= '0;
      fail_dut   <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      n_checks   <= n_checks_nxt;
      idx        <= idx_nxt;
      num_passed <= passed_nxt;
      num_failed <= failed_nxt;
      fail_idx   <= fail_idx_nxt;
      fail_ref   <= fail_ref_nxt;
      fail_dut   <= fail_dut_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_stream_check_ctrl.sv
// Scoreboard bench: expected verdicts are queued by stimulus, popped by a monitor on done rising.
module tb_stream_check_ctrl;

  typedef struct packed {
    logic        pass;
    logic        timeout;
    logic [15:0] num_passed;
    logic [15:0] num_failed;
    logic [15:0] fail_idx;
    logic [7:0]  fail_ref;
    logic [7:0]  fail_dut;
  } verdict_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_checks = '0;
  logic        ref_val = 1'b0;
  logic        ref_rdy;
  logic [7:0]  ref_msg = '0;
  logic        dut_val = 1'b0;
  logic        dut_rdy;
  logic [7:0]  dut_msg = '0;
  logic        done, pass, timeout;
  logic [15:0] num_passed, num_failed, fail_idx;
  logic [7:0]  fail_ref, fail_dut;

  int checks = 0;
  int errors = 0;
  int fires  = 0;
  verdict_t exp_q[$];
  logic done_prev = 1'b0;

  stream_check_ctrl #(
    .p_chk_nbits      (8),
    .p_cnt_nbits      (16),
    .p_timeout_period (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_checks (num_checks),
    .ref_val    (ref_val),
    .ref_rdy    (ref_rdy),
    .ref_msg    (ref_msg),
    .dut_val    (dut_val),
    .dut_rdy    (dut_rdy),
    .dut_msg    (dut_msg),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .num_passed (num_passed),
    .num_failed (num_failed),
    .fail_idx   (fail_idx),
    .fail_ref   (fail_ref),
    .fail_dut   (fail_dut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every rising done is a verdict to compare against the queue head.
  always @(negedge clk) begin
    verdict_t e;
    if (ref_val && dut_val && ref_rdy && dut_rdy) fires++;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL verdict_unexpected: done rose with no expected verdict queued");
      end else begin
        e = exp_q.pop_front();
        chk("v_pass",       32'(pass),       32'(e.pass));
        chk("v_timeout",    32'(timeout),    32'(e.timeout));
        chk("v_num_passed", 32'(num_passed), 32'(e.num_passed));
        chk("v_num_failed", 32'(num_failed), 32'(e.num_failed));
        chk("v_fail_idx",   32'(fail_idx),   32'(e.fail_idx));
        chk("v_fail_ref",   32'(fail_ref),   32'(e.fail_ref));
        chk("v_fail_dut",   32'(fail_dut),   32'(e.fail_dut));
      end
    end
    done_prev = done;
  end

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num_checks = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] r, input logic [7:0] d);
    ref_val = 1'b1; ref_msg = r;
    dut_val = 1'b1; dut_msg = d;
    @(posedge clk); #1;
    ref_val = 1'b0; dut_val = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: done not seen within %0d cycles, expected done=1", name, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_done"},    32'(done),       32'd0);
    chk({tag, "_pass"},    32'(pass),       32'd0);
    chk({tag, "_timeout"}, 32'(timeout),    32'd0);
    chk({tag, "_passed"},  32'(num_passed), 32'd0);
    chk({tag, "_failed"},  32'(num_failed), 32'd0);
    chk({tag, "_fidx"},    32'(fail_idx),   32'd0);
    chk({tag, "_rdy"},     32'({ref_rdy, dut_rdy}), 32'd0);
  endtask

  initial begin
    int f0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all_zero("reset");
    @(posedge clk); #1;

    // All four pairs match; verdict visible right after the fourth fire's edge.
    exp_q.push_back('{1'b1, 1'b0, 16'd4, 16'd0, 16'd0, 8'h00, 8'h00});
    do_start(16'd4);
    send_pair(8'h11, 8'h11);
    send_pair(8'h22, 8'h22);
    send_pair(8'h33, 8'h33);
    send_pair(8'h44, 8'h44);
    @(negedge clk);
    chk("t1_done_latency", 32'(done), 32'd1);
    @(posedge clk); #1;

    // Single mismatch at index 1.
    exp_q.push_back('{1'b0, 1'b0, 16'd2, 16'd1, 16'd1, 8'h02, 8'hFF});
    do_start(16'd3);
    send_pair(8'h01, 8'h01);
    send_pair(8'h02, 8'hFF);
    send_pair(8'h03, 8'h03);
    wait_done("t2", 5);

    // Two mismatches: only the first is captured.
    exp_q.push_back('{1'b0, 1'b0, 16'd1, 16'd2, 16'd0, 8'hA0, 8'hA1});
    do_start(16'd3);
    send_pair(8'hA0, 8'hA1);
    send_pair(8'hB0, 8'hB0);
    send_pair(8'hC0, 8'hC7);
    wait_done("t3", 5);

    // Timeout: one fire, then eight idle RUN cycles.
    exp_q.push_back('{1'b0, 1'b1, 16'd1, 16'd0, 16'd0, 8'h00, 8'h00});
    do_start(16'd2);
    send_pair(8'h55, 8'h55);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("t4_no_early_timeout", 32'(done), 32'd0);
    wait_done("t4", 5);
    chk("t4_done", 32'(done), 32'd1);

    // Reference waits five cycles for the DUT side.
    exp_q.push_back('{1'b1, 1'b0, 16'd2, 16'd0, 16'd0, 8'h00, 8'h00});
    do_start(16'd2);
    f0 = fires;
    ref_val = 1'b1; ref_msg = 8'h66; dut_msg = 8'h66;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_ref_rdy_wait", 32'(ref_rdy), 32'd0);
      chk("t5_dut_rdy_wait", 32'(dut_rdy), 32'd1);
    end
    @(posedge clk); #1;
    dut_val = 1'b1;
    @(posedge clk); #1;
    ref_val = 1'b0; dut_val = 1'b0;
    @(negedge clk);
    chk("t5_one_fire", 32'(fires - f0), 32'd1);
    chk("t5_idx", 32'(num_passed), 32'd1);
    chk("t5_not_done", 32'(done), 32'd0);
    send_pair(8'h77, 8'h77);
    wait_done("t5", 5);

    // Reset mid-run, then a one-pair run.
    do_start(16'd4);
    send_pair(8'h01, 8'h01);
    send_pair(8'h02, 8'h02);
    reset = 1'b1;
    check_all_zero("midrst");
    #1 reset = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back('{1'b1, 1'b0, 16'd1, 16'd0, 16'd0, 8'h00, 8'h00});
    do_start(16'd1);
    send_pair(8'h9C, 8'h9C);
    wait_done("t6", 5);

    // Zero checks from IDLE: immediate pass, handshakes never asserted.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back('{1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 8'h00, 8'h00});
    ref_val = 1'b1; dut_val = 1'b1;
    do_start(16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t7_done", 32'(done), 32'd1);
      chk("t7_rdy", 32'({ref_rdy, dut_rdy}), 32'd0);
    end
    ref_val = 1'b0; dut_val = 1'b0;

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
